// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding and defaults for the execute-to-memory access sequencer.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_ERR,
      ST_DUMP,
      ST_HALTED
   } mem_state_t;

   localparam int MEM_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/wait_timer.sv
// Saturating 8-bit cycle counter for the memory WAIT phase.
// expired flags the counting cycle whose edge brings the count to TIMEOUT_CYCLES.
module wait_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= 8'd0;
      end else if (inc && count != 8'hFF) begin
         count <= count + 8'd1;
      end
   end

   // Compare the post-increment value so the timeout lands exactly TIMEOUT_CYCLES edges into WAIT.
   assign expired = inc && (({1'b0, count} + 9'd1) >= LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between execute and a variable-latency data memory; one access in flight, dump on halt.
// Minimum access is 3 cycles after accept; pipeline stalled through ISSUE/WAIT and in terminal states.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_data,
   input  logic        halt,
   output logic        stall_out,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        mem_createdump,
   input  logic        mem_stall,
   input  logic        mem_done,
   input  logic [15:0] mem_data_out
);

   mem_state_t state;
   logic       lat_wr;
   logic       timer_clr;
   logic       timer_inc;
   logic       timer_expired;

   assign timer_clr = (state == ST_ISSUE);
   assign timer_inc = (state == ST_WAIT);

   wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (timer_clr),
      .inc    (timer_inc),
      .expired(timer_expired)
   );

   // RESP deliberately releases the stall so execute can advance on the done pulse.
   assign stall_out = ((state == ST_IDLE) && req_valid && !halt) ||
                      (state == ST_ISSUE) || (state == ST_WAIT) ||
                      (state == ST_ERR) || (state == ST_DUMP) || (state == ST_HALTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         lat_wr         <= 1'b0;
         mem_addr       <= 16'h0000;
         mem_data_in    <= 16'h0000;
         mem_rd         <= 1'b0;
         mem_wr         <= 1'b0;
         done           <= 1'b0;
         rd_data        <= 16'h0000;
         err            <= 1'b0;
         mem_createdump <= 1'b0;
      end else begin
         done           <= 1'b0;
         mem_createdump <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (halt) begin
                  mem_createdump <= 1'b1;
                  state          <= ST_DUMP;
               end else if (req_valid && req_addr[0]) begin
                  err   <= 1'b1;
                  state <= ST_ERR;
               end else if (req_valid) begin
                  lat_wr      <= req_wr;
                  mem_addr    <= req_addr;
                  mem_data_in <= req_data;
                  mem_rd      <= !req_wr;
                  mem_wr      <= req_wr;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!mem_stall) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_done) begin
                  if (!lat_wr) begin
                     rd_data <= mem_data_out;
                  end
                  done  <= 1'b1;
                  state <= ST_RESP;
               end else if (timer_expired) begin
                  err   <= 1'b1;
                  state <= ST_ERR;
               end
            end
            ST_RESP: state <= ST_IDLE;
            ST_DUMP: state <= ST_HALTED;
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed table, halt/reset sequences, randomized accesses vs a latency model.
module tb_mem_access_ctrl;

   localparam int T = 4;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] rdat;
      int          s;        // memory stall cycles during ISSUE
      int          k;        // mem_done in this WAIT cycle (0 = never)
      bit          exp_err;
      int          exp_end;  // cycle (accept = 0) where done pulses or err first shows
      logic [15:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [15:0] req_data = 16'h0;
   logic        halt = 1'b0;
   logic        stall_out, done, err, mem_rd, mem_wr, mem_createdump;
   logic [15:0] rd_data, mem_addr, mem_data_in;
   logic        mem_stall = 1'b0;
   logic        mem_done = 1'b0;
   logic [15:0] mem_data_out = 16'h0;
   logic [5:0]  ctl;

   int          nvec = 0;
   int          nerr = 0;
   logic [15:0] cur_rd = 16'h0;
   vec_t        tbl[10];

   always #5 clk = ~clk;

   assign ctl = {stall_out, done, err, mem_rd, mem_wr, mem_createdump};

   mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_data(req_data), .halt(halt),
      .stall_out(stall_out), .done(done), .rd_data(rd_data), .err(err),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_createdump(mem_createdump),
      .mem_stall(mem_stall), .mem_done(mem_done), .mem_data_out(mem_data_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; req_valid = 1'b0; halt = 1'b0; mem_stall = 1'b0; mem_done = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_ctl {stall,done,err,rd,wr,dump}", 32'(ctl), 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk("rst_mem_addr_data", {mem_addr, mem_data_in}, 32'h0);
      cur_rd = 16'h0;
   endtask

   // Drives one access on a fixed schedule derived from the access timing, checking every cycle.
   task automatic run_access(input vec_t v, input bit rnd);
      int         issue_end;
      bit         in_issue;
      logic [5:0] exp_ctl;
      issue_end = 1 + v.s;
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_data = v.data;
      halt = 1'b0; mem_stall = 1'b0; mem_done = 1'b0; mem_data_out = 16'($urandom);
      #1;
      chk("accept_ctl", 32'(ctl), 32'b100000);
      for (int c = 1; c <= v.exp_end + 1; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
         mem_stall = (c <= v.s);
         mem_done = (v.k != 0) && (c == issue_end + v.k);
         mem_data_out = mem_done ? v.rdat : 16'($urandom);
         if (rnd && c <= issue_end && c < v.exp_end && ($urandom % 3 == 0)) mem_done = 1'b1;
         halt = rnd && (c < v.exp_end) && ($urandom % 4 == 0);
         #1;
         in_issue = (c <= issue_end) && (c < v.exp_end);
         if (c < v.exp_end)   exp_ctl = {1'b1, 1'b0, 1'b0, in_issue & !v.wr, in_issue & v.wr, 1'b0};
         else if (v.exp_err)  exp_ctl = 6'b101000;
         else if (c == v.exp_end) exp_ctl = 6'b010000;
         else                 exp_ctl = 6'b000000;
         chk($sformatf("ctl c%0d {stall,done,err,rd,wr,dump}", c), 32'(ctl), 32'(exp_ctl));
         chk($sformatf("rd_data c%0d", c), 32'(rd_data), 32'(c < v.exp_end ? cur_rd : v.exp_rd));
         if (in_issue) chk($sformatf("cmd addr/data c%0d", c), {mem_addr, mem_data_in}, {v.addr, v.data});
      end
      cur_rd = v.exp_rd;
      if (v.exp_err) begin
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = 16'($urandom) & 16'hFFFE; halt = 1'($urandom);
            mem_done = 1'b0; mem_stall = 1'b0;
            #1;
            chk("terminal_err_ctl", 32'(ctl), 32'b101000);
         end
         do_reset();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t v;
      //             wr addr      data      rdat      s  k  err end rd
      tbl[0] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, 1'b0, 3, 16'hBEEF};
      tbl[1] = '{1'b1, 16'h0020, 16'h1234, 16'h0000, 2, 1, 1'b0, 5, 16'hBEEF};
      tbl[2] = '{1'b0, 16'h0040, 16'h0000, 16'h55AA, 1, 3, 1'b0, 6, 16'h55AA};
      tbl[3] = '{1'b0, 16'h0042, 16'h0000, 16'h0F0F, 0, 4, 1'b0, 6, 16'h0F0F};
      tbl[4] = '{1'b1, 16'h00FE, 16'hCAFE, 16'h1111, 3, 2, 1'b0, 7, 16'h0F0F};
      tbl[5] = '{1'b0, 16'h0003, 16'h0000, 16'h2222, 0, 1, 1'b1, 1, 16'h0F0F};
      tbl[6] = '{1'b0, 16'h0100, 16'h0000, 16'h3333, 1, 0, 1'b1, 7, 16'h0000};
      tbl[7] = '{1'b1, 16'h0200, 16'h4444, 16'h0000, 0, 5, 1'b1, 6, 16'h0000};
      tbl[8] = '{1'b0, 16'hFFFE, 16'h0000, 16'h8001, 0, 2, 1'b0, 4, 16'h8001};
      tbl[9] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 0, 1, 1'b1, 1, 16'h8001};

      do_reset();
      for (int i = 0; i < 10; i++) run_access(tbl[i], 1'b0);

      // halt wins over a simultaneous request: one dump pulse, no memory command
      @(posedge clk); #1;
      halt = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0010;
      #1;
      chk("halt_c0_ctl", 32'(ctl), 32'b000000);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      chk("halt_c1_dump", 32'(ctl), 32'b100001);
      for (int c = 2; c < 5; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b1;
         #1;
         chk($sformatf("halted_c%0d", c), 32'(ctl), 32'b100000);
      end
      do_reset();

      // reset in the middle of WAIT abandons the access
      @(posedge clk); #1;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0030;
      #1;
      chk("midwait_c0", 32'(ctl), 32'b100000);
      @(posedge clk); #1;
      req_valid = 1'b0; mem_stall = 1'b0;
      #1;
      chk("midwait_c1_issue", 32'(ctl), 32'b100100);
      @(posedge clk); #1;
      #1;
      chk("midwait_c2_wait", 32'(ctl), 32'b100000);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midwait_after_rst_ctl", 32'(ctl), 32'b000000);
      chk("midwait_after_rst_addr", 32'(mem_addr), 32'h0);
      cur_rd = 16'h0;
      v = '{1'b0, 16'h0032, 16'h0000, 16'h7777, 0, 1, 1'b0, 3, 16'h7777};
      run_access(v, 1'b0);

      // randomized accesses against the outcome model
      for (int n = 0; n < 60; n++) begin
         v.wr   = 1'($urandom);
         v.addr = 16'($urandom);
         if ($urandom % 8 != 0) v.addr[0] = 1'b0;
         v.data = 16'($urandom);
         v.rdat = 16'($urandom);
         v.s    = int'($urandom % 4);
         v.k    = int'($urandom % 7);
         if (v.addr[0]) begin
            v.exp_err = 1'b1; v.exp_end = 1; v.exp_rd = cur_rd;
         end else if (v.k == 0 || v.k > T) begin
            v.exp_err = 1'b1; v.exp_end = 2 + v.s + T; v.exp_rd = cur_rd;
         end else begin
            v.exp_err = 1'b0;
            v.exp_end = 3 + v.s + (v.k - 1);
            v.exp_rd  = v.wr ? cur_rd : v.rdat;
         end
         run_access(v, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
